// File: rtl/jstk_reader.sv
// PmodJSTK poller: SPI mode-0 master that reads X/Y/buttons each poll period and
// emits one-cycle direction pulses. Define JSTK_AUTOREPEAT_EN to add held-direction auto-repeat.
module jstk_reader #(
    parameter int CLK_DIV        = 50,
    parameter int SS_SETUP       = 1500,
    parameter int BYTE_GAP       = 1000,
    parameter int POLL_PERIOD    = 1000000,
    parameter int LOW_TH         = 300,
    parameter int HIGH_TH        = 700,
    parameter int REPEAT_SAMPLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic [3:0] jstkPos,
    output logic [9:0] jstk_x,
    output logic [9:0] jstk_y,
    output logic [2:0] jstk_btn,
    output logic       sample_valid
);

    localparam logic [31:0] DIV_LAST   = 32'(CLK_DIV - 1);
    localparam logic [31:0] SETUP_LAST = 32'(SS_SETUP - 1);
    localparam logic [31:0] GAP_LAST   = 32'(BYTE_GAP - 1);
    localparam logic [31:0] POLL_LAST  = 32'(POLL_PERIOD - 1);
    localparam logic [9:0]  LOW_V      = 10'(LOW_TH);
    localparam logic [9:0]  HIGH_V     = 10'(HIGH_TH);
    localparam logic [9:0]  CENTER     = 10'd512;

    // Frame starts are driven by a free-running counter, so a frame must fit inside one period.
    if (POLL_PERIOD <= SS_SETUP + 80 * CLK_DIV + 4 * BYTE_GAP + 1 || REPEAT_SAMPLES < 1
        || CLK_DIV < 1 || SS_SETUP < 1 || BYTE_GAP < 1) begin : g_param_check
        $error("jstk_reader: invalid parameter set");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] poll_reg, poll_next;
    logic [31:0] tmr_reg, tmr_next;
    logic [3:0]  half_reg, half_next;
    logic [2:0]  byte_reg, byte_next;
    logic [7:0]  tx_reg, tx_next;
    logic [7:0]  rx_reg, rx_next;
    logic [7:0]  xlo_reg, xlo_next, ylo_reg, ylo_next;
    logic [1:0]  xhi_reg, xhi_next, yhi_reg, yhi_next;
    logic [3:0]  prev_reg, prev_next;
    logic        ss_reg, ss_next, sclk_reg, sclk_next, mosi_reg, mosi_next;
    logic [3:0]  pos_reg, pos_next;
    logic [9:0]  x_reg, x_next, y_reg, y_next;
    logic [2:0]  btn_reg, btn_next;
    logic        valid_reg, valid_next;
`ifdef JSTK_AUTOREPEAT_EN
    localparam logic [15:0] REP_V = 16'(REPEAT_SAMPLES);
    logic [15:0] rep_reg, rep_next;
`endif

    logic [7:0] cmd_byte;
    logic [9:0] new_x, new_y;
    logic [3:0] dir_now, dir_rise;

    assign cmd_byte = {6'b100000, led};
    assign new_x    = {xhi_reg, xlo_reg};
    assign new_y    = {yhi_reg, ylo_reg};
    // Bit order matches jstkPos: [0] up, [1] down, [2] left, [3] right.
    assign dir_now  = {new_x > HIGH_V, new_x < LOW_V, new_y < LOW_V, new_y > HIGH_V};
    assign dir_rise = dir_now & ~prev_reg;

    always_comb begin
        state_next = state_reg;
        poll_next  = (poll_reg == POLL_LAST) ? 32'd0 : poll_reg + 32'd1;
        tmr_next   = tmr_reg;
        half_next  = half_reg;
        byte_next  = byte_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        xlo_next   = xlo_reg;
        xhi_next   = xhi_reg;
        ylo_next   = ylo_reg;
        yhi_next   = yhi_reg;
        prev_next  = prev_reg;
        ss_next    = ss_reg;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        pos_next   = 4'b0000;
        x_next     = x_reg;
        y_next     = y_reg;
        btn_next   = btn_reg;
        valid_next = 1'b0;
`ifdef JSTK_AUTOREPEAT_EN
        rep_next   = rep_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (poll_reg == POLL_LAST && en) begin
                    ss_next    = 1'b0;
                    tmr_next   = 32'd0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (tmr_reg == SETUP_LAST) begin
                    state_next = SHIFT;
                    tmr_next   = 32'd0;
                    half_next  = 4'd0;
                    byte_next  = 3'd0;
                    tx_next    = cmd_byte;
                    mosi_next  = cmd_byte[7];
                end else begin
                    tmr_next = tmr_reg + 32'd1;
                end
            end
            SHIFT: begin
                if (tmr_reg == DIV_LAST) begin
                    tmr_next  = 32'd0;
                    half_next = half_reg + 4'd1;
                    if (!half_reg[0]) begin
                        sclk_next = 1'b1;
                        rx_next   = {rx_reg[6:0], miso};
                    end else begin
                        sclk_next = 1'b0;
                        if (half_reg != 4'd15) begin
                            tx_next   = {tx_reg[6:0], 1'b0};
                            mosi_next = tx_reg[6];
                        end else begin
                            mosi_next = 1'b0;
                            if (byte_reg == 3'd4) begin
                                state_next = DONE;
                                ss_next    = 1'b1;
                                x_next     = new_x;
                                y_next     = new_y;
                                btn_next   = rx_reg[2:0];
                                valid_next = 1'b1;
                                pos_next   = dir_rise;
                                prev_next  = dir_now;
`ifdef JSTK_AUTOREPEAT_EN
                                if (dir_now == 4'b0000 || dir_rise != 4'b0000) begin
                                    rep_next = 16'd0;
                                end else if (rep_reg + 16'd1 == REP_V) begin
                                    rep_next = 16'd0;
                                    pos_next = dir_now;
                                end else begin
                                    rep_next = rep_reg + 16'd1;
                                end
`endif
                            end else begin
                                case (byte_reg)
                                    3'd0:    xlo_next = rx_reg;
                                    3'd1:    xhi_next = rx_reg[1:0];
                                    3'd2:    ylo_next = rx_reg;
                                    default: yhi_next = rx_reg[1:0];
                                endcase
                                byte_next  = byte_reg + 3'd1;
                                state_next = GAP;
                            end
                        end
                    end
                end else begin
                    tmr_next = tmr_reg + 32'd1;
                end
            end
            GAP: begin
                if (tmr_reg == GAP_LAST) begin
                    state_next = SHIFT;
                    tmr_next   = 32'd0;
                    half_next  = 4'd0;
                    tx_next    = 8'h00;
                    mosi_next  = 1'b0;
                end else begin
                    tmr_next = tmr_reg + 32'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            poll_reg  <= 32'd0;
            tmr_reg   <= 32'd0;
            half_reg  <= 4'd0;
            byte_reg  <= 3'd0;
            tx_reg    <= 8'h00;
            rx_reg    <= 8'h00;
            xlo_reg   <= 8'h00;
            xhi_reg   <= 2'b00;
            ylo_reg   <= 8'h00;
            yhi_reg   <= 2'b00;
            prev_reg  <= 4'b0000;
            ss_reg    <= 1'b1;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            pos_reg   <= 4'b0000;
            x_reg     <= CENTER;
            y_reg     <= CENTER;
            btn_reg   <= 3'b000;
            valid_reg <= 1'b0;
`ifdef JSTK_AUTOREPEAT_EN
            rep_reg   <= 16'd0;
`endif
        end else begin
            state_reg <= state_next;
            poll_reg  <= poll_next;
            tmr_reg   <= tmr_next;
            half_reg  <= half_next;
            byte_reg  <= byte_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            xlo_reg   <= xlo_next;
            xhi_reg   <= xhi_next;
            ylo_reg   <= ylo_next;
            yhi_reg   <= yhi_next;
            prev_reg  <= prev_next;
            ss_reg    <= ss_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            pos_reg   <= pos_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            btn_reg   <= btn_next;
            valid_reg <= valid_next;
`ifdef JSTK_AUTOREPEAT_EN
            rep_reg   <= rep_next;
`endif
        end
    end

    assign ss           = ss_reg;
    assign sclk         = sclk_reg;
    assign mosi         = mosi_reg;
    assign jstkPos      = pos_reg;
    assign jstk_x       = x_reg;
    assign jstk_y       = y_reg;
    assign jstk_btn     = btn_reg;
    assign sample_valid = valid_reg;

endmodule
